// File: rtl/camera_frame_stream_packer.sv
// camera_frame_stream_packer: selects one of NUM_CH pixel streams and packs a WxH frame into AXI4-Stream beats
module camera_frame_stream_packer #(
   parameter int NUM_CH = 3,
   parameter int PIX_W  = 16,
   parameter int AXIS_W = 64,
   parameter int DIM_W  = 16,
   parameter int CNT_W  = 32,
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    capture,
   input  logic [SEL_W-1:0]        ch_sel,
   input  logic [DIM_W-1:0]        image_width,
   input  logic [DIM_W-1:0]        image_height,
   input  logic [CNT_W-1:0]        timeout,
   input  logic [NUM_CH*PIX_W-1:0] ch_tdata,
   input  logic [NUM_CH-1:0]       ch_tvalid,
   input  logic [NUM_CH-1:0]       ch_sof,
   output logic [NUM_CH-1:0]       ch_tready,
   output logic [AXIS_W-1:0]       m_axis_tdata,
   output logic [AXIS_W/8-1:0]     m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout_err,
   output logic                    cfg_err,
   output logic [CNT_W-1:0]        xfer_cnt
);
   localparam int PPW   = AXIS_W / PIX_W;
   localparam int BPP   = PIX_W / 8;
   localparam int LN_W  = $clog2(PPW + 1);
   localparam int TOT_W = 2 * DIM_W;
   typedef enum logic [1:0] {IDLE, ARM, PACK, LAST} state_t;
   state_t state, state_n;
   logic [SEL_W-1:0] sel;
   logic [TOT_W-1:0] total, pix_cnt;
   logic [LN_W-1:0] lane;
   logic [AXIS_W-1:0] acc, acc_n;
   logic [CNT_W-1:0] wd;
   logic [PIX_W-1:0] pix;
   logic rdy_en, to_flag, sel_rdy, px_hs, ack, take, is_last, load, idle, expire, cap_ok;
   function automatic logic [AXIS_W/8-1:0] keep_of(input int n);
      keep_of = '0;
      for (int i = 0; i < PPW; i++) keep_of[i*BPP +: BPP] = {BPP{i < n}};
   endfunction
   assign busy    = state != IDLE;
   assign pix     = ch_tdata[sel*PIX_W +: PIX_W];
   assign sel_rdy = state == ARM || (state == PACK && (!m_axis_tvalid || m_axis_tready));
   assign px_hs   = ch_tvalid[sel] && ch_tready[sel];
   assign ack     = m_axis_tvalid && m_axis_tready;
   assign take    = px_hs && (state == PACK || (state == ARM && ch_sof[sel]));
   assign is_last = pix_cnt == total - TOT_W'(1);
   assign load    = take && (is_last || lane == LN_W'(PPW - 1));
   assign acc_n   = acc | (AXIS_W'(pix) << (lane * PIX_W));
   assign idle    = (state == ARM || state == PACK) && !px_hs && !ack;
   // a pending stalled beat holds the output register, so a PACK abort waits for it to drain
   assign expire  = timeout != '0 && idle && wd >= timeout - CNT_W'(1) && (state == ARM || !m_axis_tvalid);
   assign cap_ok  = image_width != '0 && image_height != '0 && 32'(ch_sel) < NUM_CH;
   always_comb begin
      ch_tready = '0;
      for (int k = 0; k < NUM_CH; k++) ch_tready[k] = rdy_en && (state == IDLE || sel != SEL_W'(k) || sel_rdy);
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = (capture && cap_ok) ? ARM : IDLE;
         ARM:  state_n = expire ? IDLE : take ? (is_last ? LAST : PACK) : ARM;
         PACK: state_n = (expire || (load && is_last)) ? LAST : PACK;
         LAST: state_n = ack ? IDLE : LAST;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         rdy_en <= 1'b0;
         sel <= '0;
         total <= '0;
         pix_cnt <= '0;
         lane <= '0;
         acc <= '0;
         wd <= '0;
         to_flag <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tkeep <= '0;
         m_axis_tlast <= 1'b0;
         m_axis_tvalid <= 1'b0;
         done <= 1'b0;
         timeout_err <= 1'b0;
         cfg_err <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         rdy_en <= 1'b1;
         done <= 1'b0;
         timeout_err <= 1'b0;
         cfg_err <= 1'b0;
         wd <= idle ? wd + CNT_W'(1) : '0;
         if (ack) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
            m_axis_tvalid <= 1'b0;
         end
         if (state == IDLE && capture) begin
            if (cap_ok) begin
               sel <= ch_sel;
               total <= TOT_W'(image_width) * TOT_W'(image_height);
               pix_cnt <= '0;
               lane <= '0;
               acc <= '0;
               to_flag <= 1'b0;
               xfer_cnt <= '0;
            end else cfg_err <= 1'b1;
         end
         if (take) begin
            pix_cnt <= pix_cnt + TOT_W'(1);
            if (load) begin
               m_axis_tdata <= acc_n;
               m_axis_tkeep <= keep_of(int'(lane) + 1);
               m_axis_tlast <= is_last;
               m_axis_tvalid <= 1'b1;
               acc <= '0;
               lane <= '0;
            end else begin
               acc <= acc_n;
               lane <= lane + LN_W'(1);
            end
         end
         if (expire && state == PACK) begin
            m_axis_tdata <= acc;
            m_axis_tkeep <= keep_of(int'(lane));
            m_axis_tlast <= 1'b1;
            m_axis_tvalid <= 1'b1;
            to_flag <= 1'b1;
            acc <= '0;
            lane <= '0;
         end
         if (expire && state == ARM) timeout_err <= 1'b1;
         if (state == LAST && ack) begin
            done <= !to_flag;
            timeout_err <= to_flag;
         end
      end
   end
endmodule

// File: tb/tb_camera_frame_stream_packer.sv
// tb_camera_frame_stream_packer: directed self-checking bench for camera_frame_stream_packer
module tb_camera_frame_stream_packer;
   logic sys_clk, sys_rst_n, capture;
   logic [1:0] ch_sel;
   logic [15:0] image_width, image_height;
   logic [31:0] timeout;
   logic [47:0] ch_tdata;
   logic [2:0] ch_tvalid, ch_sof, ch_tready;
   logic [63:0] m_axis_tdata;
   logic [7:0] m_axis_tkeep;
   logic m_axis_tlast, m_axis_tvalid, m_axis_tready;
   logic busy, done, timeout_err, cfg_err;
   logic [31:0] xfer_cnt;
   typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
   beat_t beats[$];
   int tests = 0, fails = 0;
   int done_cnt = 0, terr_cnt = 0, stall_seen = 0, stall_viol = 0;
   logic tog = 1'b0, prev_stall = 1'b0;
   beat_t prev_b;
   int nb, d0, t0;

   camera_frame_stream_packer dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .capture(capture), .ch_sel(ch_sel),
      .image_width(image_width), .image_height(image_height), .timeout(timeout),
      .ch_tdata(ch_tdata), .ch_tvalid(ch_tvalid), .ch_sof(ch_sof), .ch_tready(ch_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .busy(busy), .done(done),
      .timeout_err(timeout_err), .cfg_err(cfg_err), .xfer_cnt(xfer_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      #2;
      if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
      if (done) done_cnt++;
      if (timeout_err) terr_cnt++;
      if (prev_stall) begin
         stall_seen++;
         if (!m_axis_tvalid || {m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== prev_b) stall_viol++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_b = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
   end

   initial forever begin
      @(negedge sys_clk);
      if (tog) m_axis_tready = ~m_axis_tready;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [63:0] d, input logic [7:0] k, input logic l);
      beat_t b;
      b = (idx < beats.size()) ? beats[idx] : '0;
      chk({tag, ".tdata"}, b.d, d);
      chk({tag, ".tkeep"}, 64'(b.k), 64'(k));
      chk({tag, ".tlast"}, 64'(b.l), 64'(l));
   endtask

   task automatic cap(input logic [1:0] s, input logic [15:0] w, input logic [15:0] h);
      @(negedge sys_clk);
      capture = 1'b1; ch_sel = s; image_width = w; image_height = h;
      @(negedge sys_clk);
      capture = 1'b0;
   endtask

   task automatic push(input int ch, input logic [15:0] d, input logic s);
      int n = 0;
      @(negedge sys_clk);
      ch_tvalid[ch] = 1'b1; ch_tdata[ch*16 +: 16] = d; ch_sof[ch] = s;
      #1;
      while (!ch_tready[ch] && n < 100) begin
         @(negedge sys_clk);
         #1;
         n++;
      end
      if (n >= 100) chk("push_wait", 64'(n), 64'd0);
   endtask

   task automatic stop(input int ch);
      @(negedge sys_clk);
      ch_tvalid[ch] = 1'b0; ch_sof[ch] = 1'b0;
   endtask

   task automatic six_pixels();
      push(1, 16'h0001, 1'b1);
      for (int i = 2; i <= 6; i++) push(1, 16'(i), 1'b0);
      stop(1);
      repeat (5) @(negedge sys_clk);
   endtask

   initial begin
      sys_rst_n = 1'b0; capture = 1'b0; ch_sel = '0; image_width = '0; image_height = '0;
      timeout = '0; ch_tdata = '0; ch_tvalid = '0; ch_sof = '0; m_axis_tready = 1'b1;
      repeat (3) @(negedge sys_clk);
      #2;
      chk("rst.tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst.tdata", m_axis_tdata, 64'd0);
      chk("rst.tkeep_tlast", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
      chk("rst.flags", 64'({busy, done, timeout_err, cfg_err}), 64'd0);
      chk("rst.xfer_cnt", 64'(xfer_cnt), 64'd0);
      chk("rst.ch_tready", 64'(ch_tready), 64'd0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      #2;
      chk("post_rst.ch_tready", 64'(ch_tready), 64'h7);

      nb = beats.size(); d0 = done_cnt;
      cap(1, 6, 1);
      #2;
      chk("s1.busy", 64'(busy), 64'd1);
      six_pixels();
      chk("s1.nbeats", 64'(beats.size() - nb), 64'd2);
      chk_beat("s1.b0", nb, 64'h0004_0003_0002_0001, 8'hFF, 1'b0);
      chk_beat("s1.b1", nb + 1, 64'h0000_0000_0006_0005, 8'h0F, 1'b1);
      chk("s1.done", 64'(done_cnt - d0), 64'd1);
      chk("s1.xfer_cnt", 64'(xfer_cnt), 64'd2);
      chk("s1.busy_end", 64'(busy), 64'd0);

      nb = beats.size(); d0 = done_cnt;
      ch_tvalid[0] = 1'b1; ch_sof[0] = 1'b1; ch_tdata[15:0] = 16'h7777;
      ch_tvalid[2] = 1'b1; ch_tdata[47:32] = 16'h8888;
      cap(1, 6, 1);
      #2;
      chk("s2.ch_tready", 64'(ch_tready), 64'h7);
      push(1, 16'h00AA, 1'b0);
      push(1, 16'h00BB, 1'b0);
      push(1, 16'h00CC, 1'b0);
      stop(1);
      six_pixels();
      ch_tvalid[0] = 1'b0; ch_sof[0] = 1'b0; ch_tvalid[2] = 1'b0;
      chk("s2.nbeats", 64'(beats.size() - nb), 64'd2);
      chk_beat("s2.b0", nb, 64'h0004_0003_0002_0001, 8'hFF, 1'b0);
      chk_beat("s2.b1", nb + 1, 64'h0000_0000_0006_0005, 8'h0F, 1'b1);
      chk("s2.done", 64'(done_cnt - d0), 64'd1);

      nb = beats.size(); d0 = done_cnt;
      cap(1, 8, 2);
      tog = 1'b1;
      push(1, 16'h0010, 1'b1);
      for (int i = 1; i < 16; i++) push(1, 16'h0010 + 16'(i), 1'b0);
      stop(1);
      tog = 1'b0;
      @(negedge sys_clk);
      m_axis_tready = 1'b1;
      repeat (5) @(negedge sys_clk);
      chk("s3.nbeats", 64'(beats.size() - nb), 64'd4);
      chk_beat("s3.b0", nb, 64'h0013_0012_0011_0010, 8'hFF, 1'b0);
      chk_beat("s3.b1", nb + 1, 64'h0017_0016_0015_0014, 8'hFF, 1'b0);
      chk_beat("s3.b2", nb + 2, 64'h001B_001A_0019_0018, 8'hFF, 1'b0);
      chk_beat("s3.b3", nb + 3, 64'h001F_001E_001D_001C, 8'hFF, 1'b1);
      chk("s3.stalled", 64'(stall_seen > 0), 64'd1);
      chk("s3.stable", 64'(stall_viol), 64'd0);
      chk("s3.done", 64'(done_cnt - d0), 64'd1);
      chk("s3.xfer_cnt", 64'(xfer_cnt), 64'd4);

      nb = beats.size(); d0 = done_cnt; t0 = terr_cnt;
      timeout = 32'd10;
      cap(1, 8, 1);
      push(1, 16'h0021, 1'b1);
      for (int i = 2; i <= 5; i++) push(1, 16'h0020 + 16'(i), 1'b0);
      stop(1);
      repeat (30) @(negedge sys_clk);
      chk("s4.nbeats", 64'(beats.size() - nb), 64'd2);
      chk_beat("s4.b0", nb, 64'h0024_0023_0022_0021, 8'hFF, 1'b0);
      chk_beat("s4.b1", nb + 1, 64'h0000_0000_0000_0025, 8'h03, 1'b1);
      chk("s4.timeout_err", 64'(terr_cnt - t0), 64'd1);
      chk("s4.done", 64'(done_cnt - d0), 64'd0);
      chk("s4.busy", 64'(busy), 64'd0);
      timeout = '0;

      cap(1, 0, 1);
      #2;
      chk("s5.cfg_err_w0", 64'(cfg_err), 64'd1);
      chk("s5.busy_w0", 64'(busy), 64'd0);
      @(negedge sys_clk);
      #2;
      chk("s5.cfg_err_pulse", 64'(cfg_err), 64'd0);
      cap(3, 4, 1);
      #2;
      chk("s5.cfg_err_sel3", 64'(cfg_err), 64'd1);
      chk("s5.busy_sel3", 64'(busy), 64'd0);
      nb = beats.size(); d0 = done_cnt;
      cap(1, 4, 1);
      push(1, 16'h0031, 1'b1);
      push(1, 16'h0032, 1'b0);
      stop(1);
      cap(2, 4, 1);
      #2;
      chk("s5.busy_cap", 64'(busy), 64'd1);
      chk("s5.cfg_err_cap", 64'(cfg_err), 64'd0);
      push(1, 16'h0033, 1'b0);
      push(1, 16'h0034, 1'b0);
      stop(1);
      repeat (5) @(negedge sys_clk);
      chk("s5.nbeats", 64'(beats.size() - nb), 64'd1);
      chk_beat("s5.b0", nb, 64'h0034_0033_0032_0031, 8'hFF, 1'b1);
      chk("s5.done", 64'(done_cnt - d0), 64'd1);

      cap(1, 8, 1);
      push(1, 16'h0051, 1'b1);
      for (int i = 2; i <= 5; i++) push(1, 16'h0050 + 16'(i), 1'b0);
      stop(1);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      #2;
      chk("s6.tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("s6.tdata", m_axis_tdata, 64'd0);
      chk("s6.tkeep_tlast", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
      chk("s6.flags", 64'({busy, done, timeout_err, cfg_err}), 64'd0);
      chk("s6.xfer_cnt", 64'(xfer_cnt), 64'd0);
      chk("s6.ch_tready", 64'(ch_tready), 64'd0);
      sys_rst_n = 1'b1;
      nb = beats.size(); d0 = done_cnt;
      cap(1, 4, 1);
      push(1, 16'h0041, 1'b1);
      for (int i = 2; i <= 4; i++) push(1, 16'h0040 + 16'(i), 1'b0);
      stop(1);
      repeat (5) @(negedge sys_clk);
      chk("s6.nbeats", 64'(beats.size() - nb), 64'd1);
      chk_beat("s6.b0", nb, 64'h0044_0043_0042_0041, 8'hFF, 1'b1);
      chk("s6.done", 64'(done_cnt - d0), 64'd1);
      chk("s6.xfer_end", 64'(xfer_cnt), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/camera_frame_stream_packer.md
# camera_frame_stream_packer

Parametrised successor to the single-select camera-to-DMA path. It accepts NUM_CH independent pixel streams, and on a capture command it selects one channel and waits for start-of-frame. It then packs W×H pixels into AXI4-Stream beats for the S2MM DMA, with tlast/tkeep framing, a watchdog timeout and a beat counter. It sits between the camera receivers and the CPU system's S_AXIS_S2MM port, and is controlled from the AXI4-Lite register bank.

## Interface
- NUM_CH, 3: number of camera pixel streams.
- PIX_W, 16: pixel width in bits; must be a multiple of 8.
- AXIS_W, 64: output tdata width; must be a multiple of PIX_W. PPW = AXIS_W/PIX_W.
- DIM_W, 16: width of the image width/height fields.
- CNT_W, 32: width of the timeout and beat counters.
- sys_clk  in  1  single clock for all logic.
- sys_rst_n  in  1  synchronous, active-low reset.
- capture  in  1  single-cycle start request.
- ch_sel  in  $clog2(NUM_CH)  channel select; sampled only when capture is accepted.
- image_width, image_height  in  DIM_W each  frame size in pixels; sampled only when capture is accepted.
- timeout  in  CNT_W  idle-cycle limit; 0 disables the watchdog.
- ch_tdata  in  NUM_CH*PIX_W  pixel data; channel k occupies bits [k*PIX_W +: PIX_W].
- ch_tvalid, ch_sof  in  NUM_CH  per-channel pixel valid and first-pixel-of-frame flag.
- ch_tready  out  NUM_CH  per-channel ready.
- m_axis_tdata  out  AXIS_W; m_axis_tkeep  out  AXIS_W/8; m_axis_tlast, m_axis_tvalid  out  1; m_axis_tready  in  1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes normally.
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a capture.
- cfg_err  out  1  one-cycle pulse when a capture is rejected.
- xfer_cnt  out  CNT_W  count of accepted output beats in the current/last capture.

## Operation
- States: IDLE, ARM, PACK, LAST.
- IDLE:
  - capture with image_width≠0, image_height≠0 and ch_sel<NUM_CH → latch sel, total = width×height (2·DIM_W bits, no truncation), clear xfer_cnt → ARM.
  - Otherwise, capture pulses cfg_err and the state stays IDLE.
  - capture while busy is ignored (no cfg_err).
- ARM:
  - ch_tready[sel]=1. Pixels without sof are discarded.
  - The first pixel with sof is accepted as pixel 0 → PACK.
- PACK:
  - ch_tready[sel] = !m_axis_tvalid || m_axis_tready.
  - Pixels pack little-endian: pixel i of a beat goes in bits [i*PIX_W +: PIX_W].
  - A beat is issued when PPW pixels are collected, or when the last pixel (index total−1) is accepted.
  - The final beat has tlast=1, and tkeep set for the filled pixel lanes only; unused lanes of tdata are 0.
  - ch_sof inside PACK is ignored and treated as data.
- LAST: wait for the final beat's handshake, then pulse done → IDLE.
- Unselected channels: ch_tready=1 always; their data is discarded.
- Watchdog (timeout≠0):
  - Counts consecutive cycles in ARM/PACK with no pixel accepted and no beat handshake.
  - When the count reaches timeout: from ARM → IDLE with no beat emitted. From PACK → emit a terminating beat (pending pixels, their tkeep, tlast=1, tkeep=0 if no pixels pending) → LAST. LAST completion after a timeout pulses timeout_err instead of done.
- xfer_cnt increments on each tvalid&&tready and wraps at 2^CNT_W.

## Timing
- Reset (sys_rst_n=0 at a sys_clk edge): state IDLE; m_axis_tvalid, tlast, tdata, tkeep, busy, done, timeout_err, cfg_err, xfer_cnt = 0; ch_tready = 0. ch_tready becomes all-1 in the first cycle after reset release.
- Reset mid-frame abandons the frame immediately. No tlast is generated.
- capture accepted at edge N → busy=1 from N+1.
- The pixel completing a beat, accepted at edge N → m_axis_tvalid=1 from N+1.
- tdata, tkeep and tlast stay stable while tvalid && !tready.
- Throughput is one pixel per cycle while tready=1.
- cfg_err asserts in the cycle after the rejected capture. done and timeout_err assert in the cycle after the final handshake.
- A simultaneous final-beat handshake and watchdog expiry resolve as normal completion.

## Test plan
- NUM_CH=3, PIX_W=16, AXIS_W=64; capture ch_sel=1, W=6, H=1; ch1 sends sof then 6 pixels 0x0001..0x0006 → 2 beats: 0x0004_0003_0002_0001 with tkeep=FF, tlast=0; then 0x0000_0000_0006_0005 with tkeep=0F, tlast=1; done pulse; xfer_cnt=2.
- Same setup, 3 non-sof pixels on ch1 before sof → those 3 pixels are discarded and the output is identical to the first scenario. Meanwhile ch0/ch2 have ch_tready=1 and produce no output.
- W=8, H=2, m_axis_tready toggling 1/0 every cycle → 4 full beats, tlast only on beat 4, no pixel lost; tdata is held stable during stalls.
- timeout=10, W=8, H=1; stop ch1 after 5 pixels → beat 1 is full; beat 2 carries pixel 5 with tkeep=03 and tlast=1; timeout_err pulses and done stays 0.
- capture with W=0, or ch_sel=3 → cfg_err pulses 1 cycle later and busy stays 0. A capture during PACK is ignored.
- Assert sys_rst_n=0 mid-PACK → all outputs are 0 on the next cycle. A new capture then completes a W=4, H=1 frame normally.
